mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, memory address width.
REQ-002 The block SHALL have parameter DW, default 8, memory data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, maximum wait cycles for mem_ready; legal range 1..255.
REQ-004 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- req0, req1  in  1  access request from requester 0 (core) and requester 1 (loader)
- we0, we1  in  1  write enable per requester
- addr0, addr1  in  AW  address per requester
- wdata0, wdata1  in  DW  write data per requester
- gnt0, gnt1  out  1  grant; high while that requester's access is on the memory port
- done0, done1  out  1  one-cycle completion pulse
- err0, err1  out  1  one-cycle timeout flag, coincident with done
- rdata  out  DW  read data, valid while done0 or done1 is high
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion

Function
REQ-005 The block SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-006 In IDLE with any req high, the block SHALL select one requester, latch its we/addr/wdata and enter ACCESS on the next edge.
REQ-007 If exactly one req is high in IDLE, that requester SHALL be selected.
REQ-008 If both reqs are high in IDLE, the requester not granted last SHALL be selected (round-robin).
REQ-009 The last-granted indicator SHALL update at IDLE->ACCESS.
REQ-010 In ACCESS:
- mem_en SHALL be 1.
- gnt of the selected requester SHALL be 1.
- mem_we/mem_addr/mem_wdata SHALL equal the latched values and SHALL be stable for the whole state.
REQ-011 Outside ACCESS, mem_en, mem_we and both gnt SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-012 The block SHALL keep an ACCESS wait counter: cleared on ACCESS entry, incremented each ACCESS cycle with mem_ready=0.
REQ-013 ACCESS with mem_ready=1 SHALL go to RESP; mem_rdata SHALL be captured into rdata on that edge (also on writes).
REQ-014 ACCESS with mem_ready=0 and wait counter equal to TIMEOUT-1 SHALL go to RESP with err set and rdata=0.
REQ-015 RESP SHALL last exactly one cycle.
REQ-016 In RESP, the selected requester's done SHALL be 1, and its err SHALL be 1 on timeout, else 0.
REQ-017 RESP SHALL always return to IDLE; no request is sampled in RESP.
REQ-018 Minimum latency SHALL be: req sampled at edge N -> gnt high in cycle N+1 -> done high in cycle N+2 when mem_ready=1 in the first ACCESS cycle.
REQ-019 Back-to-back throughput SHALL be one access per 3 cycles minimum.
REQ-020 Requesters hold req until done; a req deasserted during ACCESS SHALL NOT abort the access, and done SHALL still pulse.
REQ-021 A req still high in the IDLE cycle after its done SHALL be treated as a new request.
REQ-022 mem_ready outside ACCESS SHALL be ignored.
REQ-023 The non-selected requester's done, err and gnt SHALL be 0 at all times during another's access.

Reset
REQ-024 rst low SHALL immediately, without waiting for clk, force:
- state IDLE
- all gnt, done, err, mem_en and mem_we = 0
- mem_addr, mem_wdata and rdata = 0
- wait counter = 0
- last-granted = requester 1, so requester 0 wins the first tie
REQ-025 Reset asserted mid-ACCESS SHALL abandon the access with no done pulse; after release, the FSM starts in IDLE.
REQ-026 The first request SHALL be sampled on the first rising edge after rst goes high.

Verification
REQ-027 The bench SHALL cover: req0=1, we0=0, addr0=8'h10, mem_ready=1 with mem_rdata=8'hA5 in the first ACCESS cycle -> gnt0 in cycle N+1, done0=1 and rdata=8'hA5 in N+2, err0=0.
REQ-028 The bench SHALL cover: req0 and req1 both held high for three transactions after reset -> grant order 0,1,0, gnt0 and gnt1 never high together.
REQ-029 The bench SHALL cover: req1=1, we1=1, addr1=8'h3C, wdata1=8'h5A, mem_ready delayed 4 cycles -> mem_we=1, mem_addr=8'h3C, mem_wdata=8'h5A stable for 5 ACCESS cycles, then done1.
REQ-030 The bench SHALL cover: mem_ready held 0 with TIMEOUT=15 -> exactly 15 ACCESS cycles, then done0=1, err0=1, rdata=0, then return to IDLE.
REQ-031 The bench SHALL cover: rst driven low in the 2nd ACCESS cycle -> gnt0 and mem_en low before the next clk edge, no done0; a held req0 is granted again after release.
REQ-032 The bench SHALL cover: req0 dropped in the first ACCESS cycle, mem_ready=1 in the 2nd -> done0 still pulses once, and no further grant follows.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single memory port.
// Each access runs IDLE -> ACCESS -> RESP and is bounded by a wait-cycle timeout.
module mem_arbiter #(
   parameter int unsigned AW      = 8,
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          done0,
   output logic          done1,
   output logic          err0,
   output logic          err1,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready
);

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e     state;
   logic       sel;       // requester owning the current access (1 = requester 1)
   logic       last;      // requester granted most recently
   logic [7:0] wait_cnt;
   logic       pick1;

   // On a tie, pick whichever requester was not granted last.
   always_comb begin
      pick1 = req1 & (~req0 | ~last);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= StIdle;
         sel       <= 1'b0;
         last      <= 1'b1;
         wait_cnt  <= '0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
         rdata     <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         err0  <= 1'b0;
         err1  <= 1'b0;
         case (state)
            StIdle: begin
               if (req0 || req1) begin
                  state     <= StAccess;
                  sel       <= pick1;
                  last      <= pick1;
                  wait_cnt  <= '0;
                  gnt0      <= ~pick1;
                  gnt1      <= pick1;
                  mem_en    <= 1'b1;
                  mem_we    <= pick1 ? we1 : we0;
                  mem_addr  <= pick1 ? addr1 : addr0;
                  mem_wdata <= pick1 ? wdata1 : wdata0;
               end
            end
            StAccess: begin
               if (mem_ready || (wait_cnt == TimeoutLast)) begin
                  state  <= StResp;
                  gnt0   <= 1'b0;
                  gnt1   <= 1'b0;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  done0  <= ~sel;
                  done1  <= sel;
                  // A late mem_ready on the final wait cycle still counts as success.
                  err0   <= ~mem_ready & ~sel;
                  err1   <= ~mem_ready & sel;
                  rdata  <= mem_ready ? mem_rdata : '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            StResp: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   a_gnt_exclusive : assert property (@(posedge clk) disable iff (!rst) !(gnt0 && gnt1));
   a_done_exclusive : assert property (@(posedge clk) disable iff (!rst) !(done0 && done1));
   a_err_with_done : assert property (@(posedge clk) disable iff (!rst)
                                      (!err0 || done0) && (!err1 || done1));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1, we0, we1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       gnt0, gnt1, done0, done1, err0, err1;
   logic [7:0] rdata;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_ready;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .err0(err0), .err1(err1), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packs {gnt0, gnt1, done0, done1, err0, err1, mem_en} for compact comparisons.
   function automatic logic [31:0] ctl();
      return {25'd0, gnt0, gnt1, done0, done1, err0, err1, mem_en};
   endfunction

   bit eg0 [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
   bit eg1 [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
   bit ed0 [9] = '{0, 1, 0, 0, 0, 0, 0, 1, 0};
   bit ed1 [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

   initial begin
      rst = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      mem_rdata = 0; mem_ready = 0;

      // Reset state
      #12;
      chk("reset_ctl", ctl(), 32'h0);
      chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
      chk("reset_mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      chk("reset_rdata", {24'd0, rdata}, 32'd0);
      rst = 1'b1;

      // Single read, minimum latency
      req0 = 1; we0 = 0; addr0 = 8'h10; mem_ready = 1; mem_rdata = 8'hA5;
      tick();
      chk("rd_gnt_ctl", ctl(), 32'b1000001);
      chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rd_mem_addr", {24'd0, mem_addr}, 32'h10);
      tick();
      chk("rd_done_ctl", ctl(), 32'b0010000);
      chk("rd_rdata", {24'd0, rdata}, 32'hA5);
      req0 = 0; mem_ready = 0;
      tick();
      chk("rd_idle_ctl", ctl(), 32'h0);

      // Round-robin after a fresh reset: grant order 0,1,0
      rst = 1'b0;
      #4;
      chk("rr_reset_ctl", ctl(), 32'h0);
      rst = 1'b1;
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h01; addr1 = 8'h02;
      mem_ready = 1; mem_rdata = 8'h11;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (i == 7) begin
            req0 = 0;
            req1 = 0;
         end
         chk($sformatf("rr_gnt0_%0d", i), {31'd0, gnt0}, {31'd0, eg0[i]});
         chk($sformatf("rr_gnt1_%0d", i), {31'd0, gnt1}, {31'd0, eg1[i]});
         chk($sformatf("rr_done0_%0d", i), {31'd0, done0}, {31'd0, ed0[i]});
         chk($sformatf("rr_done1_%0d", i), {31'd0, done1}, {31'd0, ed1[i]});
         if (i == 3) chk("rr_addr1", {24'd0, mem_addr}, 32'h02);
      end
      mem_ready = 0;

      // Write with mem_ready delayed by four cycles
      req1 = 1; we1 = 1; addr1 = 8'h3C; wdata1 = 8'h5A; mem_rdata = 8'h77;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("wr_ctl_%0d", i), ctl(), 32'b0100001);
         chk($sformatf("wr_mem_we_%0d", i), {31'd0, mem_we}, 32'd1);
         chk($sformatf("wr_addr_%0d", i), {24'd0, mem_addr}, 32'h3C);
         chk($sformatf("wr_wdata_%0d", i), {24'd0, mem_wdata}, 32'h5A);
         if (i == 4) mem_ready = 1;
         tick();
      end
      chk("wr_done_ctl", ctl(), 32'b0001000);
      chk("wr_rdata", {24'd0, rdata}, 32'h77);
      chk("wr_mem_we_off", {31'd0, mem_we}, 32'd0);
      chk("wr_addr_hold", {24'd0, mem_addr}, 32'h3C);
      req1 = 0; we1 = 0; mem_ready = 0;
      tick();
      chk("wr_idle_ctl", ctl(), 32'h0);

      // Timeout: exactly 15 ACCESS cycles, then done0 with err0 and rdata cleared
      req0 = 1; we0 = 0; addr0 = 8'h44;
      tick();
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("to_access_%0d", i), ctl(), 32'b1000001);
         tick();
      end
      chk("to_done_ctl", ctl(), 32'b0010100);
      chk("to_rdata", {24'd0, rdata}, 32'h0);
      req0 = 0;
      tick();
      chk("to_idle_ctl", ctl(), 32'h0);

      // Reset in the 2nd ACCESS cycle
      req0 = 1; addr0 = 8'h55;
      tick();
      tick();
      chk("rs_access2_ctl", ctl(), 32'b1000001);
      mem_ready = 1; mem_rdata = 8'h99;
      #2;
      rst = 1'b0;
      #1;
      chk("rs_async_ctl", ctl(), 32'h0);
      chk("rs_async_addr", {24'd0, mem_addr}, 32'h0);
      tick();
      chk("rs_held_ctl", ctl(), 32'h0);
      #3;
      rst = 1'b1;
      #1;
      chk("rs_release_ctl", ctl(), 32'h0);
      tick();
      chk("rs_regrant_ctl", ctl(), 32'b1000001);
      chk("rs_regrant_addr", {24'd0, mem_addr}, 32'h55);
      tick();
      chk("rs_done_ctl", ctl(), 32'b0010000);
      chk("rs_rdata", {24'd0, rdata}, 32'h99);
      req0 = 0; mem_ready = 0;
      tick();

      // Request dropped during ACCESS still completes, with no further grant
      req0 = 1; addr0 = 8'h66;
      tick();
      chk("dr_access1_ctl", ctl(), 32'b1000001);
      req0 = 0;
      tick();
      chk("dr_access2_ctl", ctl(), 32'b1000001);
      mem_ready = 1; mem_rdata = 8'h3E;
      tick();
      chk("dr_done_ctl", ctl(), 32'b0010000);
      chk("dr_rdata", {24'd0, rdata}, 32'h3E);
      mem_ready = 0;
      tick();
      chk("dr_idle_ctl", ctl(), 32'h0);
      tick();
      chk("dr_no_regrant_ctl", ctl(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
